// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch unit with a one-entry output
// buffer. It fetches words from instruction memory, holds one instruction for
// the decode stage, and redirects on branch/jump targets. A response that
// belongs to a superseded request is dropped.
//
// Handshakes:
//   imem_req/imem_ack : imem_req stays high with imem_addr stable until the
//                       cycle in which imem_ack=1; that cycle completes the
//                       request. imem_ack may arrive in the first request
//                       cycle. imem_rdata is only looked at when imem_ack=1.
//   out_valid/out_ready: a handoff happens in any cycle where both are high;
//                       out_instr/out_pc stay stable while out_valid=1 and
//                       out_ready=0. A redirect wins over out_ready and
//                       discards the buffered instruction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       memory request and its word-aligned address
//   imem_ack/rdata      memory response
//   redirect_valid/pc   taken branch/jump and its target (bits [1:0] ignored)
//   out_valid/ready     buffered instruction handshake to decode
//   out_instr/pc        buffered instruction word and its address
//   out_opcode/funct3/funct7  instruction fields decoded from the buffer
//   fetch_count         number of completed handoffs (wraps)
//   fsm_state           current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] fetch_count,
  output logic [1:0]  fsm_state
);

  // FETCH  : request outstanding, its response will be kept
  // DISCARD: request outstanding, its response belongs to a stale path
  // HOLD   : buffer full, waiting for decode to take it
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] buffer, buffer_next;
  logic [31:0] out_pc_q, out_pc_next;
  logic [31:0] count, count_next;
  logic [31:0] redirect_target;

  // Targets are always word aligned; the low two bits are forced to zero.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      buffer   <= NOP_INSTR;
      out_pc_q <= 32'h0;
      count    <= 32'h0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
      buffer   <= buffer_next;
      out_pc_q <= out_pc_next;
      count    <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    buffer_next   = buffer;
    out_pc_next   = out_pc_q;
    count_next    = count;

    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Response arrives together with a redirect: it is already stale,
            // so start the new request straight away.
            pc_next       = redirect_target;
            req_addr_next = redirect_target;
          end else begin
            buffer_next = imem_rdata;
            out_pc_next = req_addr;
            pc_next     = req_addr + 32'd4;
            state_next  = HOLD;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn; keep imem_addr stable and drop the
          // response when it comes back.
          pc_next    = redirect_target;
          state_next = DISCARD;
        end
      end

      DISCARD: begin
        // Later redirects overwrite earlier ones, including one in the ack cycle.
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        if (imem_ack) begin
          req_addr_next = redirect_valid ? redirect_target : pc;
          state_next    = FETCH;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_next       = redirect_target;
          req_addr_next = redirect_target;
          state_next    = FETCH;
        end else if (out_ready) begin
          count_next    = count + 32'd1;
          req_addr_next = pc;
          state_next    = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Request and valid are gated by rst so nothing is visible during reset.
  assign imem_req    = !rst && (state == FETCH || state == DISCARD);
  assign imem_addr   = req_addr;
  assign out_valid   = !rst && (state == HOLD);
  assign out_instr   = buffer;
  assign out_pc      = out_pc_q;
  assign out_opcode  = buffer[6:0];
  assign out_funct3  = buffer[14:12];
  assign out_funct7  = buffer[31:25];
  assign fetch_count = count;
  assign fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed testbench for instr_fetch. Two instances share all inputs: dut uses
// the default RESET_PC, dut_hi starts at 32'hFFFF_FFFC to exercise PC wrap.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point,
// after the registered state has settled.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req,    hi_imem_req;
  logic [31:0] imem_addr,   hi_imem_addr;
  logic        out_valid,   hi_out_valid;
  logic [31:0] out_instr,   hi_out_instr;
  logic [31:0] out_pc,      hi_out_pc;
  logic [6:0]  out_opcode,  hi_out_opcode;
  logic [2:0]  out_funct3,  hi_out_funct3;
  logic [6:0]  out_funct7,  hi_out_funct7;
  logic [31:0] fetch_count, hi_fetch_count;
  logic [1:0]  fsm_state,   hi_fsm_state;

  int checks;
  int passed;
  logic [31:0] exp_count;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst),
    .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(hi_out_valid), .out_ready(out_ready),
    .out_instr(hi_out_instr), .out_pc(hi_out_pc),
    .out_opcode(hi_out_opcode), .out_funct3(hi_out_funct3), .out_funct7(hi_out_funct7),
    .fetch_count(hi_fetch_count), .fsm_state(hi_fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    imem_ack = 1'b1;               // in-flight ack during reset must be ignored
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (out_instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h expected 00000013", out_instr); else passed++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h expected 0", out_pc); else passed++;
    checks++; if (fetch_count !== 32'h0) $display("FAIL reset_count: got %h expected 0", fetch_count); else passed++;
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL post_reset_req: got %b expected 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL post_reset_addr: got %h expected 0", imem_addr); else passed++;
    checks++; if (hi_imem_addr !== 32'hFFFF_FFFC) $display("FAIL hi_reset_addr: got %h expected fffffffc", hi_imem_addr); else passed++;
    exp_count = 32'h0;
  endtask

  task automatic test_same_cycle_ack();
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;    // addi x1, x0, 5
    tick();
    imem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL sca_valid: got %b expected 1", out_valid); else passed++;
    checks++; if (out_pc !== 32'h0) $display("FAIL sca_out_pc: got %h expected 0", out_pc); else passed++;
    checks++; if (out_instr !== 32'h0050_0093) $display("FAIL sca_instr: got %h expected 00500093", out_instr); else passed++;
    checks++; if (out_opcode !== 7'h13) $display("FAIL sca_opcode: got %h expected 13", out_opcode); else passed++;
    checks++; if (out_funct3 !== 3'h0) $display("FAIL sca_funct3: got %h expected 0", out_funct3); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL sca_req: got %b expected 0", imem_req); else passed++;
    checks++; if (hi_out_pc !== 32'hFFFF_FFFC) $display("FAIL hi_out_pc: got %h expected fffffffc", hi_out_pc); else passed++;
  endtask

  task automatic test_hold_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || imem_req !== 1'b0)
        $display("FAIL stall_ctrl[%0d]: got valid=%b req=%b expected valid=1 req=0", i, out_valid, imem_req); else passed++;
      checks++; if (out_instr !== 32'h0050_0093 || out_pc !== 32'h0)
        $display("FAIL stall_data[%0d]: got %h@%h expected 00500093@0", i, out_instr, out_pc); else passed++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    checks++; if (fetch_count !== exp_count) $display("FAIL stall_count: got %0d expected %0d", fetch_count, exp_count); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL stall_next_req: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); else passed++;
    checks++; if (hi_imem_addr !== 32'h0) $display("FAIL hi_wrap_addr: got %h expected 0", hi_imem_addr); else passed++;
  endtask

  task automatic test_field_decode();
    imem_ack = 1'b1;
    imem_rdata = 32'h4020_8033;    // sub x0, x1, x2
    tick();
    imem_ack = 1'b0;
    checks++; if (out_pc !== 32'h4) $display("FAIL dec_out_pc: got %h expected 4", out_pc); else passed++;
    checks++; if (out_opcode !== 7'h33 || out_funct3 !== 3'h0 || out_funct7 !== 7'h20)
      $display("FAIL dec_fields: got %h/%h/%h expected 33/0/20", out_opcode, out_funct3, out_funct7); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    checks++; if (fetch_count !== exp_count || imem_addr !== 32'h8)
      $display("FAIL dec_handoff: got count=%0d addr=%h expected count=%0d addr=8", fetch_count, imem_addr, exp_count); else passed++;
  endtask

  task automatic test_redirect_pending();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0)
        $display("FAIL pend_wait[%0d]: got req=%b addr=%h valid=%b expected 1/8/0", i, imem_req, imem_addr, out_valid); else passed++;
      if (i == 2) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0BAD;
      end
      tick();
    end
    imem_ack = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL pend_after: got valid=%b req=%b addr=%h expected 0/1/100", out_valid, imem_req, imem_addr); else passed++;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_2283;    // lw x5, 0(x0)
    tick();
    imem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h0000_2283)
      $display("FAIL pend_target: got valid=%b %h@%h expected 1 00002283@100", out_valid, out_instr, out_pc); else passed++;
    checks++; if (out_opcode !== 7'h03 || out_funct3 !== 3'h2)
      $display("FAIL pend_fields: got %h/%h expected 03/2", out_opcode, out_funct3); else passed++;
  endtask

  task automatic test_redirect_vs_ready();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (fetch_count !== exp_count) $display("FAIL rvr_count: got %0d expected %0d", fetch_count, exp_count); else passed++;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL rvr_req: got valid=%b req=%b addr=%h expected 0/1/200", out_valid, imem_req, imem_addr); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    exp_pc = 32'h200;
    imem_ack = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'h0010_0093 + (i << 20);
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== 32'h0010_0093 + (i << 20))
        $display("FAIL b2b_hold[%0d]: got valid=%b %h@%h expected 1 %h@%h", i, out_valid, out_instr, out_pc, 32'h0010_0093 + (i << 20), exp_pc); else passed++;
      tick();
      exp_count = exp_count + 32'd1;
      exp_pc = exp_pc + 32'd4;
      checks++; if (fetch_count !== exp_count || imem_addr !== exp_pc || imem_req !== 1'b1)
        $display("FAIL b2b_fetch[%0d]: got count=%0d addr=%h req=%b expected %0d/%h/1", i, fetch_count, imem_addr, imem_req, exp_count, exp_pc); else passed++;
    end
    imem_ack = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_discard_latest();
    // FETCH at 0x20c: redirect without ack, then redirect again with ack.
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || out_valid !== 1'b0)
      $display("FAIL disc_latest: got req=%b addr=%h valid=%b expected 1/400/0", imem_req, imem_addr, out_valid); else passed++;
    // FETCH with ack and redirect together: stay fetching at the new target.
    imem_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500 || out_valid !== 1'b0)
      $display("FAIL ack_redirect: got req=%b addr=%h valid=%b expected 1/500/0", imem_req, imem_addr, out_valid); else passed++;
  endtask

  task automatic test_reset_mid_request();
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    rst = 1'b0;
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_req: got req=%b addr=%h valid=%b expected 1/0/0", imem_req, imem_addr, out_valid); else passed++;
    checks++; if (fetch_count !== 32'h0 || out_instr !== 32'h0000_0013)
      $display("FAIL mid_reset_state: got count=%0d instr=%h expected 0/00000013", fetch_count, out_instr); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    passed = 0;
    exp_count = 32'h0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_same_cycle_ack();
    test_hold_stall();
    test_field_decode();
    test_redirect_pending();
    test_redirect_vs_ready();
    test_back_to_back();
    test_discard_latest();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
